// File: rtl/l1_resp_pkg.sv
// Shared types and constants for the L1 block responder.
package l1_resp_pkg;

    localparam int unsigned BLOCK_BITS  = 512;
    localparam int unsigned OFFSET_BITS = 6;
    localparam int unsigned WORD_BITS   = 32;
    localparam int unsigned BLOCK_WORDS = BLOCK_BITS / WORD_BITS;

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdResp,
        StWrWait,
        StWrAck
    } state_e;

endpackage

// File: rtl/block_store.sv
// DEPTH x 512-bit single-port block array: synchronous write, registered read.
module block_store
    import l1_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [BLOCK_BITS-1:0]    wdata,
    output logic [BLOCK_BITS-1:0]    rdata
);

    logic [BLOCK_BITS-1:0] mem [DEPTH];

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/l1_block_responder.sv
// L2/memory model behind one L1 DCache: fixed-latency block refills and write-backs.
// Define L1RESP_STATS_EN to add refill/write-back completion counters.
module l1_block_responder
    import l1_resp_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LATENCY = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [31:0]           req_addr_i,
    output logic                  valid_o,
    output logic [BLOCK_BITS-1:0] data_out_o,
    output logic [31:0]           addr_out_o,
    input  logic                  evict_i,
    input  logic [31:0]           evict_addr_i,
    input  logic [BLOCK_BITS-1:0] evict_data_i,
    output logic                  evict_ack_o
`ifdef L1RESP_STATS_EN
    ,
    output logic [31:0]           refill_cnt_o,
    output logic [31:0]           evict_cnt_o
`endif
);

    localparam int unsigned IDX_BITS  = $clog2(DEPTH);
    localparam int unsigned LINE_BITS = 32 - OFFSET_BITS;
    localparam int unsigned CNT_BITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

    state_e                state;
    logic [CNT_BITS-1:0]   cnt;
    logic [LINE_BITS-1:0]  line_q;
    logic [BLOCK_BITS-1:0] wdata_q;

    logic                  store_re;
    logic                  store_we;
    logic [IDX_BITS-1:0]   store_idx;

    logic                  unused_offset;
    assign unused_offset = ^{req_addr_i[OFFSET_BITS-1:0], evict_addr_i[OFFSET_BITS-1:0]};

    // With LATENCY=1 the read is issued straight from IDLE, so index comes from the live address.
    always_comb begin
        store_idx = line_q[IDX_BITS-1:0];
        if (state == StIdle) begin
            store_idx = req_addr_i[OFFSET_BITS+IDX_BITS-1:OFFSET_BITS];
        end
        store_we = (state == StWrAck);
        store_re = 1'b0;
        if (LATENCY == 1) begin
            store_re = (state == StIdle) && !evict_i && req_i;
        end else begin
            store_re = (state == StRdWait) && (cnt == '0);
        end
    end

    block_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (store_we),
        .re    (store_re),
        .idx   (store_idx),
        .wdata (wdata_q),
        .rdata (data_out_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= StIdle;
            cnt         <= '0;
            line_q      <= '0;
            wdata_q     <= '0;
            valid_o     <= 1'b0;
            evict_ack_o <= 1'b0;
            addr_out_o  <= '0;
        end else begin
            valid_o     <= 1'b0;
            evict_ack_o <= 1'b0;
            case (state)
                StIdle: begin
                    // Write-back wins a tie; the held refill is taken on a later IDLE cycle.
                    if (evict_i) begin
                        line_q  <= evict_addr_i[31:OFFSET_BITS];
                        wdata_q <= evict_data_i;
                        cnt     <= CNT_LOAD;
                        if (LATENCY == 1) begin
                            state       <= StWrAck;
                            evict_ack_o <= 1'b1;
                        end else begin
                            state <= StWrWait;
                        end
                    end else if (req_i) begin
                        line_q <= req_addr_i[31:OFFSET_BITS];
                        cnt    <= CNT_LOAD;
                        if (LATENCY == 1) begin
                            state      <= StRdResp;
                            valid_o    <= 1'b1;
                            addr_out_o <= {req_addr_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        end else begin
                            state <= StRdWait;
                        end
                    end
                end
                StRdWait: begin
                    if (cnt == '0) begin
                        state      <= StRdResp;
                        valid_o    <= 1'b1;
                        addr_out_o <= {line_q, {OFFSET_BITS{1'b0}}};
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StWrWait: begin
                    if (cnt == '0) begin
                        state       <= StWrAck;
                        evict_ack_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StRdResp: state <= StIdle;
                StWrAck:  state <= StIdle;
                default:  state <= StIdle;
            endcase
        end
    end

`ifdef L1RESP_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            refill_cnt_o <= '0;
            evict_cnt_o  <= '0;
        end else begin
            if (state == StRdResp) begin
                refill_cnt_o <= refill_cnt_o + 32'd1;
            end
            if (state == StWrAck) begin
                evict_cnt_o <= evict_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_block_responder.sv
// Scoreboard bench for l1_block_responder (DEPTH=16, LATENCY=4), directed vectors.
module tb_l1_block_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic [31:0]  req_addr = '0;
    logic         valid;
    logic [511:0] data_out;
    logic [31:0]  addr_out;
    logic         evict = 1'b0;
    logic [31:0]  evict_addr = '0;
    logic [511:0] evict_data = '0;
    logic         evict_ack;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit           ack;
        int           cyc;
        logic [31:0]  addr;
        logic [511:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic [511:0] blk_dead;
    logic [511:0] blk_4;
    logic [511:0] blk_p;

    l1_block_responder #(
        .DEPTH   (16),
        .LATENCY (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_addr_i   (req_addr),
        .valid_o      (valid),
        .data_out_o   (data_out),
        .addr_out_o   (addr_out),
        .evict_i      (evict),
        .evict_addr_i (evict_addr),
        .evict_data_i (evict_data),
        .evict_ack_o  (evict_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every pulse, and flags entries whose due cycle has passed.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_%s: no pulse by cycle %0d (due %0d)",
                         sb[0].ack ? "ack" : "refill", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (valid || evict_ack) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: valid=%0b ack=%0b at cycle %0d, none expected",
                             valid, evict_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.ack) begin
                        if (!evict_ack || valid || cyc != e.cyc) begin
                            bad++;
                            $display("FAIL ack: got ack=%0b valid=%0b cyc=%0d, want ack=1 cyc=%0d",
                                     evict_ack, valid, cyc, e.cyc);
                        end
                    end else begin
                        if (!valid || evict_ack || cyc != e.cyc || addr_out !== e.addr ||
                            data_out !== e.data) begin
                            bad++;
                            $display("FAIL refill: got v=%0b cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                                     valid, cyc, addr_out, data_out, e.cyc, e.addr, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic push(input bit ack, input int due, input logic [31:0] a, input logic [511:0] d);
        exp_t x;
        x.ack  = ack;
        x.cyc  = due;
        x.addr = a;
        x.data = d;
        sb.push_back(x);
    endtask

    // Bounded wait for a handshake pulse; a miss is reported by the monitor.
    task automatic wait_pulse(input bit ack);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack ? evict_ack : valid) break;
        end
    endtask

    task automatic do_evict(input logic [31:0] a, input logic [511:0] d);
        @(negedge clk);
        #1;
        evict      = 1'b1;
        evict_addr = a;
        evict_data = d;
        push(1'b1, cyc + 5, '0, '0);
        wait_pulse(1'b1);
        #1 evict = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] a, input logic [31:0] ea, input logic [511:0] d);
        @(negedge clk);
        #1;
        req      = 1'b1;
        req_addr = a;
        push(1'b0, cyc + 5, ea, d);
        wait_pulse(1'b0);
        #1 req = 1'b0;
    endtask

    initial begin
        blk_dead = {16{32'hDEAD_BEEF}};
        blk_4    = '0;
        blk_4[31:0]    = 32'h1234_5678;
        blk_4[511:480] = 32'hCAFE_000F;
        for (int w = 0; w < 16; w++) blk_p[32*w +: 32] = 32'hA500_0000 | w;

        // Power-up reset
        repeat (3) @(negedge clk);
        chk("rst_valid", {511'b0, valid}, '0);
        chk("rst_ack", {511'b0, evict_ack}, '0);
        chk("rst_data", data_out, '0);
        chk("rst_addr", {480'b0, addr_out}, '0);
        #1 rst = 1'b0;

        // Write-back then refill of the same block (offset bits ignored)
        do_evict(32'h0000_0140, blk_dead);
        do_req(32'h0000_0144, 32'h0000_0140, blk_dead);
        @(negedge clk);
        chk("hold_addr", {480'b0, addr_out}, {480'b0, 32'h0000_0140});
        chk("hold_data", data_out, blk_dead);

        // Simultaneous evict and refill: evict first, refill accepted after one IDLE cycle
        @(negedge clk);
        #1;
        evict      = 1'b1;
        evict_addr = 32'h0000_0280;
        evict_data = blk_4;
        req        = 1'b1;
        req_addr   = 32'h0000_0280;
        push(1'b1, cyc + 5, '0, '0);
        push(1'b0, cyc + 11, 32'h0000_0280, blk_4);
        wait_pulse(1'b1);
        #1 evict = 1'b0;
        wait_pulse(1'b0);
        #1 req = 1'b0;

        // Aliasing: 0x540 maps to index 5
        do_req(32'h0000_0540, 32'h0000_0540, blk_dead);

        // Top index, aliased read back
        do_evict(32'h0000_03C0, blk_p);
        do_req(32'h0000_07C4, 32'h0000_07C0, blk_p);

        // Reset during RD_WAIT: no pulse, held request served after re-accept
        @(negedge clk);
        #1;
        req      = 1'b1;
        req_addr = 32'h0000_0140;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", {511'b0, valid}, '0);
        chk("midrst_ack", {511'b0, evict_ack}, '0);
        chk("midrst_data", data_out, '0);
        chk("midrst_addr", {480'b0, addr_out}, '0);
        sb.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        push(1'b0, cyc + 5, 32'h0000_0140, blk_dead);
        wait_pulse(1'b0);
        #1 req = 1'b0;

        repeat (10) @(negedge clk);
        #1;
        chk("sb_drained", 512'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
